llr_frame_loader: RTL and testbench
===================================

Name: llr_frame_loader

Overview:
- Upstream feeder for the BCJR max-product decoder.
- Accepts channel LLRs as a stream, one symbol (BITS_PER_SYMBOL LLRs) per beat, under a valid/ready handshake.
- Assembles SYMBOLS beats into the parallel LLRVector[BITS_PER_SYMBOL][SYMBOLS] frame and presents it with a one-cycle out_valid pulse.
- Pads short frames, truncates long frames and flags both, so the decoder always receives well-formed frames.

Parameters:
- BITS, 16, width of one LLR word (half-precision float pattern, passed through untouched)
- BITS_PER_SYMBOL, 2, LLRs per trellis output symbol
- SYMBOLS, 10, symbols per decoder frame
- PAD_VALUE, 16'h0000, LLR word written into padded positions (zero = erasure)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_symbol  input  BITS x [BITS_PER_SYMBOL]  LLRs of one symbol; index h maps to LLRVector[h][idx]
- in_last  input  1  marks the final beat of a frame
- out_valid  output  1  one-cycle pulse: LLRVector holds a new complete frame
- LLRVector  output  BITS x [BITS_PER_SYMBOL][SYMBOLS]  registered frame; held stable between pulses
- frame_short  output  1  pulse with out_valid: frame was padded
- frame_long  output  1  pulse with out_valid: frame was truncated
- frames_out  output  16  count of published frames; wraps 16'hFFFF -> 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, frame_short, frame_long, frames_out, all LLRVector words = 0.
  - Write index wr_idx = 0; state = FILL.
  - in_ready = 0 while rst_n is low.
  - A partially filled frame is discarded and never published.
- Accept: beat transfers when in_valid && in_ready on a rising edge. in_valid while in_ready = 0 is ignored; upstream must hold data.
- Storage: internal fill buffer plus the output register LLRVector (double buffer). Fill of the next frame proceeds while the previous frame is held on LLRVector.
- FILL (in_ready = 1):
  - An accepted beat writes fill[wr_idx]; wr_idx increments.
  - Accept at wr_idx = SYMBOLS-1 with in_last: publish; wr_idx = 0; stay FILL.
  - Accept at wr_idx = SYMBOLS-1 without in_last: publish with frame_long; go to DROP.
  - Accept at wr_idx = k < SYMBOLS-1 with in_last: go to PAD; wr_idx = k+1.
- PAD (in_ready = 0):
  - Writes PAD_VALUE to every LLR of fill[wr_idx], one symbol per cycle.
  - At wr_idx = SYMBOLS-1: publish with frame_short; wr_idx = 0; go to FILL.
  - Pad duration is SYMBOLS-1-k cycles.
- DROP (in_ready = 1): accepted beats are discarded. An accepted beat with in_last returns to FILL with wr_idx = 0. Nothing is published from DROP.
- Publish:
  - On the publishing edge, LLRVector loads the complete fill buffer, including the symbol or pad written that same cycle (bypass merge).
  - out_valid goes high for exactly one cycle; flags ride with it; frames_out increments.
- Latency:
  - Normal frame: last beat accepted at edge t -> out_valid and new LLRVector visible after edge t+1.
  - Short frame (in_last at index k): out_valid after edge t+1+(SYMBOLS-1-k).
- Throughput: back-to-back full frames with no bubbles; in_ready stays 1 and out_valid pulses every SYMBOLS cycles.
- Boundary cases:
  - Single-beat frame (k = 0): pads SYMBOLS-1 symbols.
  - in_last exactly at SYMBOLS-1: normal frame, no flag.
  - Downstream has no backpressure. LLRVector is overwritten only at the next publish, so it is stable for at least SYMBOLS cycles.

Test Plan:
- Full frame, SYMBOLS=10, BITS_PER_SYMBOL=2: beats i=0..9 with in_symbol = {16'h0100+i, 16'h0200+i}, in_last on beat 9 -> one out_valid pulse one cycle after beat 9; LLRVector[0][i] = 0x0100+i and LLRVector[1][i] = 0x0200+i; flags 0; frames_out = 1.
- Two frames back-to-back, in_valid continuously high -> in_ready never drops; out_valid pulses exactly 10 cycles apart; first frame's data held unchanged for 10 cycles; second frame correct.
- Short frame, in_last on beat 3 -> in_ready low for 6 cycles; out_valid 7 cycles after beat 3 with frame_short = 1; symbols 4..9 = 0x0000; symbols 0..3 = stimulus.
- Long frame of 13 beats, in_last on beat 12 -> out_valid one cycle after beat 9 with frame_long = 1 and holding beats 0..9; beats 10..12 dropped; following normal frame published correctly with flags 0.
- rst_n pulsed low asynchronously after 5 beats accepted -> all outputs 0 immediately; no out_valid from the partial frame; next full frame publishes correctly with frames_out = 1.
- Random in_valid gaps (50% duty) over 3 frames -> identical LLRVector contents to the gap-free run; out_valid exactly one cycle after each final accepted beat.

Source files
------------

// File: rtl/llr_frame_loader_if.sv
// Stream-in / frame-out bundle for the LLR frame loader.
// The slave side is the loader itself; the master side is whoever feeds it and takes its frames.
interface llr_frame_loader_if #(
  parameter int BITS            = 16,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 10
);
  logic                                               in_valid;
  logic                                               in_ready;
  logic [BITS_PER_SYMBOL-1:0][BITS-1:0]               in_symbol;
  logic                                               in_last;
  logic                                               out_valid;
  logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0]  LLRVector;
  logic                                               frame_short;
  logic                                               frame_long;
  logic [15:0]                                        frames_out;

  modport master (
    output in_valid, in_symbol, in_last,
    input  in_ready, out_valid, LLRVector, frame_short, frame_long, frames_out
  );

  modport slave (
    input  in_valid, in_symbol, in_last,
    output in_ready, out_valid, LLRVector, frame_short, frame_long, frames_out
  );
endinterface

// File: rtl/llr_frame_loader.sv
// Collects one symbol of LLRs per beat into a fill buffer and publishes whole decoder frames,
// padding short frames with erasures and dropping the tail of long ones.
//
// state   | meaning
// ST_FILL | accepting beats into fill[wr_idx]
// ST_PAD  | writing PAD_VALUE into the remaining symbols, input stalled
// ST_DROP | frame already published as long; discarding beats up to in_last
module llr_frame_loader #(
  parameter int              BITS            = 16,
  parameter int              BITS_PER_SYMBOL = 2,
  parameter int              SYMBOLS         = 10,
  parameter logic [BITS-1:0] PAD_VALUE       = 16'h0000
) (
  input logic               clk,
  input logic               rst_n,
  llr_frame_loader_if.slave bus
);
  localparam int IDX_W = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMBOLS - 1);

  typedef logic [BITS_PER_SYMBOL-1:0][BITS-1:0] sym_t;
  typedef enum logic [1:0] {ST_FILL, ST_PAD, ST_DROP} state_t;

  state_t                                            state;
  logic [IDX_W-1:0]                                  wr_idx;
  logic                                              ready_q;
  sym_t                                              fill [SYMBOLS];
  sym_t                                              pad_sym;
  sym_t                                              wr_sym;
  logic                                              ready;
  logic                                              accept;
  logic                                              wr_en;
  logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] merged;

  assign ready        = rst_n & ready_q;
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid & ready;
  assign wr_en        = ((state == ST_FILL) && accept) || (state == ST_PAD);
  assign wr_sym       = (state == ST_PAD) ? pad_sym : bus.in_symbol;

  always_comb begin
    pad_sym = '0;
    for (int h = 0; h < BITS_PER_SYMBOL; h++) pad_sym[h] = PAD_VALUE;
  end

  // The symbol written on the publishing edge is merged in so the frame leaves without an extra cycle.
  always_comb begin
    merged = '0;
    for (int s = 0; s < SYMBOLS; s++) begin
      for (int h = 0; h < BITS_PER_SYMBOL; h++) begin
        merged[h][s] = (wr_en && (wr_idx == IDX_W'(s))) ? wr_sym[h] : fill[s][h];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_FILL;
      wr_idx          <= '0;
      ready_q         <= 1'b1;
      for (int s = 0; s < SYMBOLS; s++) fill[s] <= '0;
      bus.out_valid   <= 1'b0;
      bus.frame_short <= 1'b0;
      bus.frame_long  <= 1'b0;
      bus.frames_out  <= '0;
      bus.LLRVector   <= '0;
    end else begin
      bus.out_valid   <= 1'b0;
      bus.frame_short <= 1'b0;
      bus.frame_long  <= 1'b0;
      if (wr_en) fill[wr_idx] <= wr_sym;

      case (state)
        ST_FILL: begin
          if (accept) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx         <= '0;
              bus.LLRVector  <= merged;
              bus.out_valid  <= 1'b1;
              bus.frames_out <= bus.frames_out + 16'd1;
              if (!bus.in_last) begin
                bus.frame_long <= 1'b1;
                state          <= ST_DROP;
              end
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
              if (bus.in_last) begin
                state   <= ST_PAD;
                ready_q <= 1'b0;
              end
            end
          end
        end
        ST_PAD: begin
          if (wr_idx == LAST_IDX) begin
            wr_idx          <= '0;
            bus.LLRVector   <= merged;
            bus.out_valid   <= 1'b1;
            bus.frame_short <= 1'b1;
            bus.frames_out  <= bus.frames_out + 16'd1;
            state           <= ST_FILL;
            ready_q         <= 1'b1;
          end else begin
            wr_idx <= wr_idx + IDX_W'(1);
          end
        end
        ST_DROP: begin
          if (accept && bus.in_last) state <= ST_FILL;
        end
        default: begin
          state   <= ST_FILL;
          wr_idx  <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_llr_frame_loader.sv
// Randomised bench for llr_frame_loader: a frame-level queue model is compared against the DUT
// every cycle, and directed frames pin the model with hand-computed values.
`timescale 1ns/1ps
module tb_llr_frame_loader;
  localparam int BITS = 16;
  localparam int BPS  = 2;
  localparam int SYM  = 10;
  localparam logic [BITS-1:0] PAD = 16'h0000;
  localparam int VW = SYM * BPS * BITS;

  typedef logic [BPS-1:0][BITS-1:0]          sym_t;
  typedef logic [BPS-1:0][SYM-1:0][BITS-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  llr_frame_loader_if #(.BITS(BITS), .BITS_PER_SYMBOL(BPS), .SYMBOLS(SYM)) bus ();

  llr_frame_loader #(.BITS(BITS), .BITS_PER_SYMBOL(BPS), .SYMBOLS(SYM), .PAD_VALUE(PAD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // frame-level model state
  sym_t        beats[$];
  int          pad_left = 0;
  bit          dropping = 0;
  vec_t        m_vec = '0;
  logic [15:0] m_cnt = '0;
  bit          m_valid = 0, m_short = 0, m_long = 0;

  // publish log taken from the DUT, used only by the literal checks
  vec_t        pub_vec[$];
  int          pub_cyc[$];
  bit          pub_short[$];
  bit          pub_long[$];
  logic [15:0] pub_cnt[$];
  int          cyc = 0;
  int          last_acc_cyc = 0;

  function automatic vec_t frame_of(sym_t q[$]);
    vec_t v;
    for (int s = 0; s < SYM; s++)
      for (int h = 0; h < BPS; h++)
        v[h][s] = (s < q.size()) ? q[s][h] : PAD;
    return v;
  endfunction

  function automatic void model_publish(bit short_f, bit long_f);
    m_vec   = frame_of(beats);
    m_valid = 1;
    m_short = short_f;
    m_long  = long_f;
    m_cnt   = m_cnt + 16'd1;
    beats.delete();
  endfunction

  function automatic void model_step();
    m_valid = 0; m_short = 0; m_long = 0;
    if (pad_left > 0) begin
      pad_left--;
      if (pad_left == 0) model_publish(1'b1, 1'b0);
    end else if (bus.in_valid) begin
      if (dropping) begin
        if (bus.in_last) dropping = 0;
      end else begin
        beats.push_back(bus.in_symbol);
        if (beats.size() == SYM) begin
          dropping = !bus.in_last;
          model_publish(1'b0, !bus.in_last);
        end else if (bus.in_last) begin
          pad_left = SYM - beats.size();
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      beats.delete();
      pad_left = 0; dropping = 0;
      m_vec = '0; m_cnt = '0; m_valid = 0; m_short = 0; m_long = 0;
    end
    chk("in_ready",    VW'(bus.in_ready),    VW'(rst_n && (pad_left == 0)));
    chk("out_valid",   VW'(bus.out_valid),   VW'(m_valid));
    chk("frame_short", VW'(bus.frame_short), VW'(m_short));
    chk("frame_long",  VW'(bus.frame_long),  VW'(m_long));
    chk("frames_out",  VW'(bus.frames_out),  VW'(m_cnt));
    chk("LLRVector",   bus.LLRVector,        m_vec);
    if (bus.out_valid) begin
      pub_vec.push_back(bus.LLRVector);
      pub_cyc.push_back(cyc);
      pub_short.push_back(bus.frame_short);
      pub_long.push_back(bus.frame_long);
      pub_cnt.push_back(bus.frames_out);
    end
    if (rst_n) model_step();
  end

  task automatic idle(input int n);
    bus.in_valid = 0;
    bus.in_last  = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input sym_t d, input bit last, input int gap);
    int waited = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      bus.in_valid = 0;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1;
    bus.in_symbol = d;
    bus.in_last   = last;
    forever begin
      @(negedge clk); #1;
      if (bus.in_ready) begin
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 100) begin
        n_total++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        break;
      end
    end
    bus.in_valid = 0;
    bus.in_last  = 0;
  endtask

  task automatic send_frame(input sym_t d[$], input int last_at, input int gap);
    for (int i = 0; i < d.size(); i++) send_beat(d[i], i == last_at, gap);
  endtask

  function automatic sym_t tp_sym(int i);
    sym_t s;
    s[0] = 16'h0100 + 16'(i);
    s[1] = 16'h0200 + 16'(i);
    return s;
  endfunction

  function automatic void rnd_frame(output sym_t q[$], input int n);
    sym_t s;
    q.delete();
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < BPS; h++) s[h] = BITS'($urandom);
      q.push_back(s);
    end
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_out_valid",  VW'(bus.out_valid),  '0);
    chk("rst_frames_out", VW'(bus.frames_out), '0);
    chk("rst_LLRVector",  bus.LLRVector,       '0);
    chk("rst_in_ready",   VW'(bus.in_ready),   '0);
    @(negedge clk); #2;
    rst_n = 1;
    idle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    sym_t q[$], q2[$], fr[3][$];
    vec_t ref_vec[3];
    int   p0;
    bus.in_valid = 0; bus.in_last = 0; bus.in_symbol = '0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1;
    chk("reset_frames_out", VW'(bus.frames_out), '0);
    chk("reset_out_valid",  VW'(bus.out_valid),  '0);
    idle(1);

    // full frame with the directed pattern
    q.delete();
    for (int i = 0; i < SYM; i++) q.push_back(tp_sym(i));
    p0 = pub_cyc.size();
    send_frame(q, SYM - 1, 0);
    idle(3);
    chk("full_pub_count", VW'(pub_cyc.size() - p0), VW'(1));
    if (pub_cyc.size() > p0) begin
      chk("full_latency", VW'(pub_cyc[p0] - last_acc_cyc), VW'(1));
      for (int i = 0; i < SYM; i++) begin
        chk("full_llr0", VW'(pub_vec[p0][0][i]), VW'(16'h0100 + i));
        chk("full_llr1", VW'(pub_vec[p0][1][i]), VW'(16'h0200 + i));
      end
      chk("full_flags", VW'({pub_short[p0], pub_long[p0]}), '0);
      chk("full_count", VW'(pub_cnt[p0]), VW'(1));
    end

    // two frames back to back
    rnd_frame(q, SYM); rnd_frame(q2, SYM);
    p0 = pub_cyc.size();
    send_frame(q, SYM - 1, 0);
    send_frame(q2, SYM - 1, 0);
    idle(2);
    chk("b2b_pub_count", VW'(pub_cyc.size() - p0), VW'(2));
    if (pub_cyc.size() > p0 + 1) begin
      chk("b2b_spacing", VW'(pub_cyc[p0 + 1] - pub_cyc[p0]), VW'(SYM));
      chk("b2b_frame2",  pub_vec[p0 + 1], frame_of(q2));
    end

    // short frame ending on beat 3
    rnd_frame(q, 4);
    p0 = pub_cyc.size();
    send_frame(q, 3, 0);
    idle(10);
    chk("short_pub_count", VW'(pub_cyc.size() - p0), VW'(1));
    if (pub_cyc.size() > p0) begin
      chk("short_latency", VW'(pub_cyc[p0] - last_acc_cyc), VW'(7));
      chk("short_flag", VW'({pub_short[p0], pub_long[p0]}), VW'(2'b10));
      for (int i = 0; i < SYM; i++)
        for (int h = 0; h < BPS; h++)
          chk("short_sym", VW'(pub_vec[p0][h][i]), (i < 4) ? VW'(q[i][h]) : '0);
    end

    // long frame of 13 beats, then a normal frame
    rnd_frame(q, 13); rnd_frame(q2, SYM);
    p0 = pub_cyc.size();
    send_frame(q, 12, 0);
    send_frame(q2, SYM - 1, 0);
    idle(2);
    chk("long_pub_count", VW'(pub_cyc.size() - p0), VW'(2));
    if (pub_cyc.size() > p0 + 1) begin
      chk("long_flag",  VW'({pub_short[p0], pub_long[p0]}), VW'(2'b01));
      chk("long_data",  pub_vec[p0], frame_of(q[0:SYM-1]));
      chk("after_long_flags", VW'({pub_short[p0 + 1], pub_long[p0 + 1]}), '0);
      chk("after_long_data",  pub_vec[p0 + 1], frame_of(q2));
    end

    // reset in the middle of a frame
    rnd_frame(q, SYM);
    p0 = pub_cyc.size();
    for (int i = 0; i < 5; i++) send_beat(q[i], 1'b0, 0);
    pulse_reset();
    chk("partial_not_published", VW'(pub_cyc.size() - p0), '0);
    q.delete();
    for (int i = 0; i < SYM; i++) q.push_back(tp_sym(i + 16));
    send_frame(q, SYM - 1, 0);
    idle(2);
    chk("post_rst_pub_count", VW'(pub_cyc.size() - p0), VW'(1));
    if (pub_cyc.size() > p0) begin
      chk("post_rst_count", VW'(pub_cnt[p0]), VW'(1));
      chk("post_rst_data",  VW'(pub_vec[p0][1][9]), VW'(16'h0219));
    end

    // same three frames without and with input gaps
    for (int f = 0; f < 3; f++) rnd_frame(fr[f], SYM);
    p0 = pub_cyc.size();
    for (int f = 0; f < 3; f++) send_frame(fr[f], SYM - 1, 0);
    idle(2);
    chk("nogap_pub_count", VW'(pub_cyc.size() - p0), VW'(3));
    for (int f = 0; f < 3; f++) ref_vec[f] = (pub_vec.size() > p0 + f) ? pub_vec[p0 + f] : '0;
    for (int f = 0; f < 3; f++) begin
      p0 = pub_cyc.size();
      send_frame(fr[f], SYM - 1, 50);
      idle(1);
      chk("gap_pub_count", VW'(pub_cyc.size() - p0), VW'(1));
      if (pub_cyc.size() > p0) begin
        chk("gap_latency", VW'(pub_cyc[p0] - last_acc_cyc), VW'(1));
        chk("gap_same_as_nogap", pub_vec[p0], ref_vec[f]);
      end
    end

    // random frame lengths and gaps against the model
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(14, 1);
      rnd_frame(q, n);
      send_frame(q, n - 1, $urandom_range(50, 0));
    end
    idle(SYM + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
